// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage between the PC register and IF/ID.
// Keeps at most one instruction-memory request outstanding, advances the PC
// register through pc_ce, and honours hazard-unit stall and branch flush,
// including discarding a response that is still in flight at flush time.
// Optional feature macro: IF_MISALIGN_CHECK_EN adds ifid_misalign and blocks
// fetch from a PC whose low two bits are non-zero.
module if_fetch_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_ce,
  input  logic            stall,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
`ifdef IF_MISALIGN_CHECK_EN
  output logic            ifid_misalign,
`endif
  output logic [31:0]     ifid_inst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state;
  logic            kill;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_inst;
  logic            hold_vld;
  logic            misalign_c;
  logic            fire_c;

  // Low PC bits only matter when the misalignment check is built in
`ifdef IF_MISALIGN_CHECK_EN
  assign misalign_c = (pc_in[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Request side: one request per PC, suppressed by stall, flush or a bad PC
  always_comb begin
    fire_c    = (state == REQ) && !stall && !flush && !misalign_c;
    imem_req  = fire_c;
    imem_addr = pc_in & ~XLEN'(3);
    pc_ce     = rst && ((fire_c && imem_gnt) || flush);
  end

  // Fetch FSM together with the IF/ID pipeline register and hold buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      kill       <= 1'b0;
      req_pc     <= '0;
      hold_pc    <= '0;
      hold_inst  <= NOP_INST;
      hold_vld   <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_inst  <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
      ifid_misalign <= 1'b0;
`endif
    end else begin
      // IF/ID defaults: bubble unless stalled; flush always bubbles
      if (flush || !stall) begin
        ifid_valid <= 1'b0;
        ifid_inst  <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
        ifid_misalign <= 1'b0;
`endif
      end

      case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (!flush) begin
            if (misalign_c && !stall) begin
              // Park a marked bubble in IF/ID; stay here until redirected
              ifid_valid <= 1'b1;
              ifid_pc    <= pc_in;
              ifid_inst  <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
              ifid_misalign <= 1'b1;
`endif
            end else if (fire_c && imem_gnt) begin
              req_pc <= pc_in;
              state  <= WAIT;
            end
          end
        end

        WAIT: begin
          if (flush) begin
            // A response in this same cycle settles the debt; otherwise owe it
            if (imem_rvalid) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else if (!stall) begin
              ifid_valid <= 1'b1;
              ifid_pc    <= req_pc;
              ifid_inst  <= imem_rdata;
              state      <= REQ;
            end else begin
              hold_pc   <= req_pc;
              hold_inst <= imem_rdata;
              hold_vld  <= 1'b1;
              state     <= HOLD;
            end
          end
        end

        HOLD: begin
          if (flush) begin
            hold_vld <= 1'b0;
            state    <= REQ;
          end else if (!stall) begin
            if (hold_vld) begin
              ifid_valid <= 1'b1;
              ifid_pc    <= hold_pc;
              ifid_inst  <= hold_inst;
            end
            hold_vld <= 1'b0;
            state    <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, streaming, stall, flush cases.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_ce;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
`ifdef IF_MISALIGN_CHECK_EN
  logic        ifid_misalign;
`endif

  int total = 0;
  int bad   = 0;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_ce       (pc_ce),
    .stall       (stall),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (gnt),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .ifid_valid  (ifid_valid),
    .ifid_pc     (ifid_pc),
`ifdef IF_MISALIGN_CHECK_EN
    .ifid_misalign (ifid_misalign),
`endif
    .ifid_inst   (ifid_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; pc_in = '0; stall = 1'b0; flush = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req",  32'(imem_req), 32'd0);
    chk("rst_pce",  32'(pc_ce), 32'd0);
    chk("rst_vld",  32'(ifid_valid), 32'd0);
    chk("rst_inst", ifid_inst, NOP);
    chk("rst_pc",   ifid_pc, 32'd0);
    rst = 1'b1; #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    tick(); #1;
    chk("first_req",  32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming: grant immediately, response one cycle later
    gnt = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_req",  32'(imem_req), 32'd1);
      chk("t2_addr", imem_addr, 32'(4 * i));
      chk("t2_pce",  32'(pc_ce), 32'd1);
      tick();
      pc_in = 32'(4 * (i + 1)); rvalid = 1'b1; rdata = 32'h00A0_0000 + 32'(i); #1;
      chk("t2_wait_req", 32'(imem_req), 32'd0);
      chk("t2_wait_pce", 32'(pc_ce), 32'd0);
      chk("t2_bubble",   32'(ifid_valid), 32'd0);
      tick();
      rvalid = 1'b0; #1;
      chk("t2_vld",  32'(ifid_valid), 32'd1);
      chk("t2_pc",   ifid_pc, 32'(4 * i));
      chk("t2_inst", ifid_inst, 32'h00A0_0000 + 32'(i));
    end

    // Stall over the response: IF/ID and PC frozen, then buffered data lands
    pc_in = 32'h4; #1;
    chk("t3_pce_grant", 32'(pc_ce), 32'd1);
    tick();
    pc_in = 32'h8; stall = 1'b1; rvalid = 1'b1; rdata = 32'h0050_0093; #1;
    chk("t3_rv_req", 32'(imem_req), 32'd0);
    chk("t3_rv_pce", 32'(pc_ce), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      rvalid = 1'b0; #1;
      chk("t3_hold_vld",  32'(ifid_valid), 32'd0);
      chk("t3_hold_pc",   ifid_pc, 32'h8);
      chk("t3_hold_inst", ifid_inst, NOP);
      chk("t3_hold_pce",  32'(pc_ce), 32'd0);
      chk("t3_hold_req",  32'(imem_req), 32'd0);
    end
    stall = 1'b0; #1;
    chk("t3_rel_pce", 32'(pc_ce), 32'd0);
    tick(); #1;
    chk("t3_vld",  32'(ifid_valid), 32'd1);
    chk("t3_pc",   ifid_pc, 32'h4);
    chk("t3_inst", ifid_inst, 32'h0050_0093);
    chk("t3_next_addr", imem_addr, 32'h8);

    // Flush while a request is in flight: late response is discarded
    chk("t4_pce_grant", 32'(pc_ce), 32'd1);
    tick();
    pc_in = 32'hC; flush = 1'b1; #1;
    chk("t4_flush_pce", 32'(pc_ce), 32'd1);
    chk("t4_flush_req", 32'(imem_req), 32'd0);
    tick();
    pc_in = 32'h40; flush = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    chk("t4_kill_req", 32'(imem_req), 32'd0);
    tick();
    rvalid = 1'b0; #1;
    chk("t4_vld",  32'(ifid_valid), 32'd0);
    chk("t4_inst", ifid_inst, NOP);
    chk("t4_req",  32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h40);

    // Flush, stall and response together
    tick();
    pc_in = 32'h44; flush = 1'b1; stall = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_0BAD; #1;
    chk("t5_pce", 32'(pc_ce), 32'd1);
    tick();
    pc_in = 32'h80; flush = 1'b0; stall = 1'b0; rvalid = 1'b0; #1;
    chk("t5_vld",  32'(ifid_valid), 32'd0);
    chk("t5_inst", ifid_inst, NOP);
    chk("t5_req",  32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h80);

    // Two flushes while one response is owed: exactly one response dropped
    tick();
    pc_in = 32'h84; flush = 1'b1; #1;
    tick();
    pc_in = 32'h90; #1;
    chk("t7_pce2", 32'(pc_ce), 32'd1);
    tick();
    pc_in = 32'hA0; flush = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111; #1;
    tick();
    rvalid = 1'b0; #1;
    chk("t7_drop_inst", ifid_inst, NOP);
    chk("t7_drop_vld",  32'(ifid_valid), 32'd0);
    chk("t7_addr",      imem_addr, 32'hA0);
    tick();
    pc_in = 32'hA4; rvalid = 1'b1; rdata = 32'h2222_2222; #1;
    tick();
    rvalid = 1'b0; #1;
    chk("t7_vld",  32'(ifid_valid), 32'd1);
    chk("t7_pc",   ifid_pc, 32'hA0);
    chk("t7_inst", ifid_inst, 32'h2222_2222);

    // Stall in REQ: grant ignored, stray response ignored, IF/ID held
    stall = 1'b1; rvalid = 1'b1; rdata = 32'h3333_3333; #1;
    chk("req_stall_req", 32'(imem_req), 32'd0);
    chk("req_stall_pce", 32'(pc_ce), 32'd0);
    tick(); #1;
    chk("req_stall_vld",  32'(ifid_valid), 32'd1);
    chk("req_stall_inst", ifid_inst, 32'h2222_2222);
    stall = 1'b0; rvalid = 1'b0; #1;

    // Flush while holding a buffered response
    tick();
    pc_in = 32'hA8; stall = 1'b1; rvalid = 1'b1; rdata = 32'h4444_4444; #1;
    tick();
    rvalid = 1'b0; flush = 1'b1; #1;
    chk("hold_flush_pce", 32'(pc_ce), 32'd1);
    tick();
    flush = 1'b0; stall = 1'b0; pc_in = 32'hC0; #1;
    chk("hold_flush_req",  32'(imem_req), 32'd1);
    chk("hold_flush_addr", imem_addr, 32'hC0);
    chk("hold_flush_vld",  32'(ifid_valid), 32'd0);
    chk("hold_flush_inst", ifid_inst, NOP);
    tick();
    pc_in = 32'hC4; rvalid = 1'b1; rdata = 32'h5555_5555; #1;
    tick();
    rvalid = 1'b0; #1;
    chk("post_hold_pc",   ifid_pc, 32'hC0);
    chk("post_hold_inst", ifid_inst, 32'h5555_5555);

    // Asynchronous reset in the middle of a request
    tick();
    pc_in = 32'hC8; rst = 1'b0; #1;
    chk("t1_req",  32'(imem_req), 32'd0);
    chk("t1_vld",  32'(ifid_valid), 32'd0);
    chk("t1_inst", ifid_inst, NOP);
    chk("t1_pc",   ifid_pc, 32'h0);
    chk("t1_pce",  32'(pc_ce), 32'd0);
    rvalid = 1'b1; rdata = 32'h6666_6666;
    tick();
    rst = 1'b1; #1;
    chk("t1_idle_req", 32'(imem_req), 32'd0);
    tick();
    gnt = 1'b0; #1;
    chk("t1_req_again", 32'(imem_req), 32'd1);
    chk("t1_addr",      imem_addr, 32'hC8);
    tick(); #1;
    chk("t1_late_vld",  32'(ifid_valid), 32'd0);
    chk("t1_late_inst", ifid_inst, NOP);
    rvalid = 1'b0;

`ifdef IF_MISALIGN_CHECK_EN
    // Misaligned PC blocks fetch until a flush redirects it
    pc_in = 32'h102; gnt = 1'b1; #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_pce", 32'(pc_ce), 32'd0);
    tick(); #1;
    chk("t6_mis",  32'(ifid_misalign), 32'd1);
    chk("t6_vld",  32'(ifid_valid), 32'd1);
    chk("t6_pc",   ifid_pc, 32'h102);
    chk("t6_inst", ifid_inst, NOP);
    chk("t6_req2", 32'(imem_req), 32'd0);
    flush = 1'b1; #1;
    chk("t6_flush_pce", 32'(pc_ce), 32'd1);
    tick();
    pc_in = 32'h200; flush = 1'b0; #1;
    chk("t6_resume_req",  32'(imem_req), 32'd1);
    chk("t6_resume_addr", imem_addr, 32'h200);
    chk("t6_mis_clr",     32'(ifid_misalign), 32'd0);
`else
    // Without the check the low PC bits are simply masked off
    pc_in = 32'h102; gnt = 1'b1; #1;
    chk("t6_req",  32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, 32'h100);
    chk("t6_pce",  32'(pc_ce), 32'd1);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
